// File: rtl/ei_mem_pkg.sv
// Shared types for the register-file access path.
package ei_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE
  } arb_state_t;

  localparam int ARB_MAX_REQ = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick; the last-grant pointer is owned by the caller.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               grant_vld
);

  logic [IW:0] cand;

  // Walk last_grant+1 .. last_grant+NUM_REQ (mod NUM_REQ); first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = {1'b0, last_grant} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!grant_vld && req[cand[IW-1:0]]) begin
        grant[cand[IW-1:0]] = 1'b1;
        grant_idx           = cand[IW-1:0];
        grant_vld           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regs_access_arbiter.sv
// Shares the register file's single port between NUM_REQ requesters, one
// byte access per grant, 3-cycle accept-to-response.
module regs_access_arbiter
  import ei_mem_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 64,
  parameter int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_write,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata,
  output logic                                  rsp_err,
  input  logic [DATA_DEPTH-1:0]                 mode_mask,
  output logic [ADDR_WIDTH-1:0]                 regs_addr,
  output logic                                  regs_read_en,
  output logic                                  regs_write_en,
  output logic [DATA_WIDTH-1:0]                 regs_write_data,
  input  logic [DATA_WIDTH-1:0]                 regs_read_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t state, state_nxt;

  logic [IW-1:0]            last_grant, grant_idx, op_owner;
  logic [NUM_REQ-1:0]       grant;
  logic                     grant_vld;
  logic                     op_write, op_err;
  logic [2**ADDR_WIDTH-1:0] mask_ext;
  logic                     sel_write, sel_err;
  logic [ADDR_WIDTH-1:0]    sel_addr;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_vld  (grant_vld)
  );

  // Mask is padded to the full address space so out-of-range lookups read 0.
  always_comb begin
    mask_ext                 = '0;
    mask_ext[DATA_DEPTH-1:0] = mode_mask;
    sel_write                = req_write[grant_idx];
    sel_addr                 = req_addr[grant_idx];
    sel_err                  = ({1'b0, sel_addr} >= (ADDR_WIDTH+1)'(DATA_DEPTH)) ||
                               (sel_write && mask_ext[sel_addr]);
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready = grant;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant      <= IW'(NUM_REQ - 1);
      op_owner        <= '0;
      op_write        <= 1'b0;
      op_err          <= 1'b0;
      regs_addr       <= '0;
      regs_write_data <= '0;
      regs_read_en    <= 1'b0;
      regs_write_en   <= 1'b0;
      rsp_valid       <= '0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
    end else begin
      regs_read_en  <= 1'b0;
      regs_write_en <= 1'b0;
      rsp_valid     <= '0;
      unique case (state)
        IDLE: begin
          if (grant_vld) begin
            last_grant      <= grant_idx;
            op_owner        <= grant_idx;
            op_write        <= sel_write;
            op_err          <= sel_err;
            regs_addr       <= sel_addr;
            regs_write_data <= req_wdata[grant_idx];
            regs_write_en   <= sel_write && !sel_err;
            regs_read_en    <= !sel_write && !sel_err;
          end
        end
        CAPTURE: begin
          rsp_valid <= NUM_REQ'(1) << op_owner;
          rsp_err   <= op_err;
          rsp_rdata <= (!op_write && !op_err) ? regs_read_data : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regs_access_arbiter.sv
// Directed bench for regs_access_arbiter with a behavioural register file.
module tb_regs_access_arbiter;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int DD = 48;
  localparam int AW = 6;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req_valid, req_write, req_ready, rsp_valid;
  logic [NR-1:0][AW-1:0]  req_addr;
  logic [NR-1:0][DW-1:0]  req_wdata;
  logic [DW-1:0]          rsp_rdata, regs_write_data, regs_read_data;
  logic                   rsp_err, regs_read_en, regs_write_en;
  logic [DD-1:0]          mode_mask;
  logic [AW-1:0]          regs_addr;

  int n_vec = 0;
  int n_miss = 0;

  regs_access_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .mode_mask       (mode_mask),
    .regs_addr       (regs_addr),
    .regs_read_en    (regs_read_en),
    .regs_write_en   (regs_write_en),
    .regs_write_data (regs_write_data),
    .regs_read_data  (regs_read_data)
  );

  always #5 clk = ~clk;

  // Register file model: mem[i] = 3*i+1, except mem[0] = 0xA7.
  logic [DW-1:0] mem [DD];
  logic          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < DD; i++) mem[i] <= DW'(i * 3 + 1);
      mem[0]   <= 8'hA7;
      mem_init <= 1'b1;
      regs_read_data <= '0;
    end else begin
      if (regs_write_en && regs_addr < AW'(DD) && !mode_mask[regs_addr]) mem[regs_addr] <= regs_write_data;
      if (regs_read_en && regs_addr < AW'(DD)) regs_read_data <= mem[regs_addr];
    end
  end

  // Monitors sample mid-cycle.
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, rsp0_cnt = 0, rsp1_cnt = 0;
  int acc_idx[$];
  int acc_cyc[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (regs_write_en) wr_cnt++;
      if (regs_read_en)  rd_cnt++;
      if (rsp_valid[0])  rsp0_cnt++;
      if (rsp_valid[1])  rsp1_cnt++;
      if (|req_ready) begin
        acc_idx.push_back(req_ready[1] ? 1 : 0);
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle just after the edge; returns in the response cycle.
  task automatic access(input string tag, input bit r, input bit w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit e, input logic [DW-1:0] rd);
    req_valid[r] = 1'b1; req_write[r] = w; req_addr[r] = a; req_wdata[r] = d;
    #1;
    check({tag, "_ready"}, 32'(req_ready), r ? 32'h2 : 32'h1);
    step();
    req_valid[r] = 1'b0;
    check({tag, "_en"}, {30'd0, regs_write_en, regs_read_en}, {30'd0, w && !e, !w && !e});
    if (!e) check({tag, "_addr"}, 32'(regs_addr), 32'(a));
    if (w && !e) check({tag, "_wdata"}, 32'(regs_write_data), 32'(d));
    step();
    check({tag, "_en_off"}, {30'd0, regs_write_en, regs_read_en}, 32'd0);
    check({tag, "_no_rsp"}, 32'(rsp_valid), 32'd0);
    step();
    check({tag, "_rsp_valid"}, 32'(rsp_valid), r ? 32'h2 : 32'h1);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'(e));
    check({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'(rd));
  endtask

  int base_acc, base_wr, base_rd, base_r0, base_r1, n;

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    mode_mask = '0;
    mode_mask[0] = 1'b1;
    repeat (3) step();
    check("rst_outs", {rsp_valid, req_ready, rsp_err, regs_read_en, regs_write_en},  '0);
    check("rst_data", {8'd0, rsp_rdata, regs_write_data, 2'd0, regs_addr}, '0);
    rst_n = 1'b1;
    step();

    access("wr5", 1'b0, 1'b1, 6'd5, 8'h3C, 1'b0, 8'h00);
    access("rd5", 1'b0, 1'b0, 6'd5, 8'h00, 1'b0, 8'h3C);
    base_wr = wr_cnt;
    access("wr_ro", 1'b1, 1'b1, 6'd0, 8'h55, 1'b1, 8'h00);
    check("wr_ro_no_pulse", 32'(wr_cnt - base_wr), 32'd0);
    access("rd_ro", 1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 8'hA7);
    access("rd_oob", 1'b0, 1'b0, 6'd50, 8'h00, 1'b1, 8'h00);
    step();

    // Reset while a write is on the port.
    base_wr = wr_cnt; base_r0 = rsp0_cnt + rsp1_cnt;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 6'd9; req_wdata[0] = 8'hEE;
    step();
    req_valid[0] = 1'b0;
    check("rst_mid_we", 32'(regs_write_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_drop", {22'd0, regs_write_en, regs_read_en, regs_addr, 2'd0}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    repeat (4) step();
    check("rst_mid_no_rsp", 32'(rsp0_cnt + rsp1_cnt - base_r0), 32'd0);
    check("rst_mid_no_wr", 32'(wr_cnt - base_wr), 32'd0);

    // Both requesters continuously valid.
    base_acc = acc_idx.size(); base_r0 = rsp0_cnt; base_r1 = rsp1_cnt;
    req_write = '0; req_addr[0] = 6'd5; req_addr[1] = 6'd7;
    req_valid = 2'b11;
    n = 0;
    while (acc_idx.size() < base_acc + 12 && n < 80) begin
      step();
      n++;
    end
    req_valid = '0;
    repeat (3) step();
    check("rr_count", 32'(acc_idx.size() - base_acc), 32'd12);
    for (int k = 0; k < 12 && base_acc + k < acc_idx.size(); k++) begin
      check($sformatf("rr_grant%0d", k), 32'(acc_idx[base_acc + k]), 32'(k % 2));
      if (k > 0) check($sformatf("rr_gap%0d", k), 32'(acc_cyc[base_acc + k] - acc_cyc[base_acc + k - 1]), 32'd3);
    end
    check("rr_rsp0", 32'(rsp0_cnt - base_r0), 32'd6);
    check("rr_rsp1", 32'(rsp1_cnt - base_r1), 32'd6);
    check("rr_last_rdata", 32'(rsp_rdata), 32'h16);

    // Req0 withdraws while req1 is in flight.
    base_acc = acc_idx.size(); base_wr = wr_cnt; base_rd = rd_cnt;
    base_r0 = rsp0_cnt; base_r1 = rsp1_cnt;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 6'd7;
    #1;
    check("wd_ready1", 32'(req_ready), 32'h2);
    step();
    req_valid[1] = 1'b0;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 6'd3; req_wdata[0] = 8'h11;
    step();
    req_valid[0] = 1'b0;
    repeat (6) step();
    check("wd_accepts", 32'(acc_idx.size() - base_acc), 32'd1);
    check("wd_rsp0", 32'(rsp0_cnt - base_r0), 32'd0);
    check("wd_rsp1", 32'(rsp1_cnt - base_r1), 32'd1);
    check("wd_wr", 32'(wr_cnt - base_wr), 32'd0);
    check("wd_rd", 32'(rd_cnt - base_rd), 32'd1);
    check("wd_rdata", 32'(rsp_rdata), 32'h16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
